// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioner: debounce FSM encoding and default timings.
package button_conditioner_pkg;

    localparam logic [1:0] StUp          = 2'd0;
    localparam logic [1:0] StConfirmDown = 2'd1;
    localparam logic [1:0] StDown        = 2'd2;
    localparam logic [1:0] StConfirmUp   = 2'd3;

    localparam int unsigned DEBOUNCE_CYCLES_10MS = 250000;
    localparam int unsigned RESET_PULSE_DEFAULT  = 65536;

endpackage

// File: rtl/button_debounce.sv
// Single push-button channel: 2-flop synchronizer, debounce FSM with confirm counter,
// registered level plus one-cycle press/release pulses.
module button_debounce
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
    input  logic clk25,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            s;

    // Synchronized pin, inverted to active-high (1 = pressed).
    assign s = ~sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], btn_n_i};
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            StUp: begin
                if (s) begin
                    state_d = StConfirmDown;
                    cnt_d   = '0;
                end
            end
            StConfirmDown: begin
                if (!s) begin
                    state_d = StUp;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StDown;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDown: begin
                if (!s) begin
                    state_d = StConfirmUp;
                    cnt_d   = '0;
                end
            end
            StConfirmUp: begin
                if (s) begin
                    state_d = StDown;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StUp;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StUp;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= StUp;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// DE0 push-button front end: per-button debounce channels plus the stretched active-low
// core reset, fired on power-up and on every debounced BUTTON[0] press.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_10MS,
    parameter int unsigned RESET_PULSE_CYCLES = RESET_PULSE_DEFAULT
) (
    input  logic                   clk25,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_n,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic                   sys_rst_n
);

    localparam int unsigned RcntW = $clog2(RESET_PULSE_CYCLES + 1);
    localparam logic [RcntW-1:0] RcntLoad = RcntW'(RESET_PULSE_CYCLES);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk25    (clk25),
            .rst      (rst),
            .btn_n_i  (btn_n[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic             sys_rst_n_q, sys_rst_n_d;

    // Only press events reload; holding BUTTON[0] lets the pulse expire normally.
    always_comb begin
        rcnt_d = rcnt_q;
        if (btn_press[0]) begin
            rcnt_d = RcntLoad;
        end else if (rcnt_q != '0) begin
            rcnt_d = rcnt_q - RcntW'(1);
        end
        sys_rst_n_d = (rcnt_d == '0);
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            rcnt_q      <= RcntLoad;
            sys_rst_n_q <= 1'b0;
        end else begin
            rcnt_q      <= rcnt_d;
            sys_rst_n_q <= sys_rst_n_d;
        end
    end

    assign sys_rst_n = sys_rst_n_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: instance A uses DEBOUNCE_CYCLES=4, instance B uses
// DEBOUNCE_CYCLES=1 for the mid-pulse reload case; both use RESET_PULSE_CYCLES=8.
module tb_button_conditioner;

    logic       clk25 = 1'b0;
    logic       rst;
    logic [2:0] a_btn_n, b_btn_n;
    logic [2:0] a_level, a_press, a_release;
    logic [2:0] b_level, b_press, b_release;
    logic       a_sys_rst_n, b_sys_rst_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk25 = ~clk25;

    button_conditioner #(
        .NUM_BUTTONS       (3),
        .DEBOUNCE_CYCLES   (4),
        .RESET_PULSE_CYCLES(8)
    ) u_dut_a (
        .clk25      (clk25),
        .rst        (rst),
        .btn_n      (a_btn_n),
        .btn_level  (a_level),
        .btn_press  (a_press),
        .btn_release(a_release),
        .sys_rst_n  (a_sys_rst_n)
    );

    button_conditioner #(
        .NUM_BUTTONS       (3),
        .DEBOUNCE_CYCLES   (1),
        .RESET_PULSE_CYCLES(8)
    ) u_dut_b (
        .clk25      (clk25),
        .rst        (rst),
        .btn_n      (b_btn_n),
        .btn_level  (b_level),
        .btn_press  (b_press),
        .btn_release(b_release),
        .sys_rst_n  (b_sys_rst_n)
    );

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk25);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_btn_n = 3'b111;
        b_btn_n = 3'b111;

        // Power-up
        tick(3);
        check("rst_level", 32'(a_level), 32'h0);
        check("rst_press", 32'(a_press), 32'h0);
        check("rst_release", 32'(a_release), 32'h0);
        check("rst_sys_a", 32'(a_sys_rst_n), 32'h0);
        check("rst_sys_b", 32'(b_sys_rst_n), 32'h0);
        rst = 1'b0;
        check("pwr_sys_low_start", 32'(a_sys_rst_n), 32'h0);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check("pwr_sys_low", 32'(a_sys_rst_n), 32'h0);
        end
        tick(1);
        check("pwr_sys_high_a", 32'(a_sys_rst_n), 32'h1);
        check("pwr_sys_high_b", 32'(b_sys_rst_n), 32'h1);
        tick(3);
        check("pwr_sys_stays_high", 32'(a_sys_rst_n), 32'h1);

        // Clean press and release on button 1
        a_btn_n[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("press1_early", 32'(a_press), 32'h0);
        end
        tick(1);
        check("press1_pulse", 32'(a_press), 32'h2);
        check("press1_level", 32'(a_level), 32'h2);
        check("press1_no_sys_rst", 32'(a_sys_rst_n), 32'h1);
        tick(1);
        check("press1_width", 32'(a_press), 32'h0);
        check("press1_level_held", 32'(a_level), 32'h2);
        a_btn_n[1] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("release1_early", 32'(a_release), 32'h0);
        end
        tick(1);
        check("release1_pulse", 32'(a_release), 32'h2);
        check("release1_level", 32'(a_level), 32'h0);
        tick(1);
        check("release1_width", 32'(a_release), 32'h0);

        // Bounce on button 2: 3-cycle runs for 30 cycles, then stable low
        for (int r = 0; r < 10; r++) begin
            a_btn_n[2] = 1'(r % 2);
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check("bounce_no_press", 32'(a_press), 32'h0);
                check("bounce_no_level", 32'(a_level), 32'h0);
            end
        end
        a_btn_n[2] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("bounce_settle_early", 32'(a_press), 32'h0);
        end
        tick(1);
        check("bounce_single_press", 32'(a_press), 32'h4);
        tick(1);
        check("bounce_press_width", 32'(a_press), 32'h0);
        a_btn_n[2] = 1'b1;
        tick(8);
        check("bounce_released", 32'(a_level), 32'h0);

        // BUTTON[0] triggers the reset pulse; holding it does not extend it
        a_btn_n[0] = 1'b0;
        tick(7);
        check("btn0_press", 32'(a_press), 32'h1);
        check("btn0_sys_before_fall", 32'(a_sys_rst_n), 32'h1);
        tick(1);
        check("btn0_sys_fall", 32'(a_sys_rst_n), 32'h0);
        for (int i = 2; i <= 8; i++) begin
            tick(1);
            check("btn0_sys_low", 32'(a_sys_rst_n), 32'h0);
        end
        tick(1);
        check("btn0_sys_high", 32'(a_sys_rst_n), 32'h1);
        tick(4);
        check("btn0_hold_no_extend", 32'(a_sys_rst_n), 32'h1);
        check("btn0_hold_level", 32'(a_level), 32'h1);
        a_btn_n[0] = 1'b1;
        tick(8);
        check("btn0_released", 32'(a_level), 32'h0);

        // Instance B: second BUTTON[0] press mid-pulse reloads a full pulse
        b_btn_n[0] = 1'b0;
        tick(4);
        check("reload_first_press", 32'(b_press), 32'h1);
        b_btn_n[0] = 1'b1;
        tick(1);
        check("reload_sys_fall", 32'(b_sys_rst_n), 32'h0);
        tick(1);
        b_btn_n[0] = 1'b0;
        tick(2);
        check("reload_release", 32'(b_release), 32'h1);
        tick(2);
        check("reload_second_press", 32'(b_press), 32'h1);
        tick(3);
        check("reload_extends", 32'(b_sys_rst_n), 32'h0);
        tick(5);
        check("reload_still_low", 32'(b_sys_rst_n), 32'h0);
        tick(1);
        check("reload_sys_high", 32'(b_sys_rst_n), 32'h1);
        b_btn_n[0] = 1'b1;
        tick(6);
        check("reload_b_released", 32'(b_level), 32'h0);

        // Simultaneous presses and releases on all three buttons
        a_btn_n = 3'b000;
        tick(6);
        check("simul_early", 32'(a_press), 32'h0);
        tick(1);
        check("simul_press", 32'(a_press), 32'h7);
        check("simul_level", 32'(a_level), 32'h7);
        tick(1);
        check("simul_press_width", 32'(a_press), 32'h0);
        a_btn_n = 3'b111;
        tick(7);
        check("simul_release", 32'(a_release), 32'h7);
        check("simul_level_low", 32'(a_level), 32'h0);
        tick(1);

        // Async reset while button 1 is confirming and button 2 is down
        a_btn_n[2] = 1'b0;
        tick(7);
        check("async_pre_level2", 32'(a_level), 32'h4);
        a_btn_n[1] = 1'b0;
        tick(4);
        check("async_pre_no_press", 32'(a_press), 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("async_clear_level", 32'(a_level), 32'h0);
        check("async_clear_press", 32'(a_press), 32'h0);
        check("async_clear_sys", 32'(a_sys_rst_n), 32'h0);
        tick(2);
        check("async_hold_press", 32'(a_press), 32'h0);
        check("async_hold_release", 32'(a_release), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("async_post_early", 32'(a_press), 32'h0);
        end
        tick(1);
        check("async_post_press", 32'(a_press), 32'h6);
        check("async_post_level", 32'(a_level), 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
